// File: rtl/store_unit.sv
// store_unit: memory-write path of the CPU.
// Accepts one SB/SH/SW store per handshake, rejects misaligned or illegal
// requests, and writes a word-wide data memory with no byte enables.
// Sub-word stores are done as read-modify-write: read the word, merge the
// byte/halfword in little-endian order, then write the whole word back.
// ADDR_W is expected to be at most 29 so the word address fits in req_addr.
module store_unit #(
  parameter int ADDR_W  = 14,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              done,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  localparam logic [2:0] F_SB = 3'b000;
  localparam logic [2:0] F_SH = 3'b001;
  localparam logic [2:0] F_SW = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_ERR
  } state_t;

  state_t             r_state;
  logic [ADDR_W+1:0]  r_addr;     // captured byte address (word address + lane)
  logic [15:0]        r_wdata;    // only the low halfword is ever merged
  logic               r_is_half;  // 1 = SH, 0 = SB (SW never reaches the merge)
  logic [31:0]        r_merge;    // word presented on mem_wdata
  logic [CNT_W-1:0]   r_cnt;      // remaining read-latency cycles
  logic               r_ready;
  logic               r_done;
  logic               r_misalign;
  logic               r_rd_en;
  logic               r_we;

  logic               w_illegal;
  logic [31:0]        w_merged;
  logic               w_unused_addr;

  // Address bits above the memory's reach are deliberately dropped.
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  // Decide whether an incoming request must be rejected.
  always_comb begin
    w_illegal = 1'b1;
    case (req_funct3)
      F_SB:    w_illegal = 1'b0;
      F_SH:    w_illegal = req_addr[0];
      F_SW:    w_illegal = |req_addr[1:0];
      default: w_illegal = 1'b1;
    endcase
  end

  // Overlay the captured byte/halfword onto the word returned by memory.
  always_comb begin
    w_merged = mem_rdata;
    if (r_is_half) begin
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
    end else begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end
  end

  // Store FSM with registered strobes; pulses default low every cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_half  <= 1'b0;
      r_merge    <= '0;
      r_cnt      <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_rd_en    <= 1'b0;
      r_we       <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_rd_en    <= 1'b0;
      r_we       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr    <= req_addr[ADDR_W+1:0];
            r_wdata   <= req_wdata[15:0];
            r_is_half <= (req_funct3 == F_SH);
            r_ready   <= 1'b0;
            if (w_illegal) begin
              r_state    <= S_ERR;
              r_misalign <= 1'b1;
            end else if (req_funct3 == F_SW) begin
              // Full word: nothing to merge, write straight away.
              r_merge <= req_wdata;
              r_state <= S_WRITE;
              r_we    <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_rd_en <= 1'b1;
            end
          end
        end
        S_READ: begin
          r_cnt   <= CNT_W'(MEM_LAT);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            // Read data is valid exactly in the last wait cycle.
            r_merge <= w_merged;
            r_state <= S_WRITE;
            r_we    <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign done      = r_done;
  assign misalign  = r_misalign;
  assign mem_rd_en = r_rd_en;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr[ADDR_W+1:2];
  assign mem_wdata = r_merge;

endmodule

// File: tb/tb_store_unit.sv
// Testbench for store_unit: directed store scenarios followed by random
// traffic, with a reference memory model and a scoreboard monitor.
module tb_store_unit;

  localparam int ADDR_W = 14;
  localparam int LAT    = 1;
  localparam int NWORDS = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [2:0]        req_funct3 = '0;
  logic              done;
  logic              misalign;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;

  store_unit #(.ADDR_W(ADDR_W), .MEM_LAT(LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .done       (done),
    .misalign   (misalign),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural data memory with LAT-cycle read pipeline; garbage when idle.
  logic [31:0] ram  [NWORDS];
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    pipe[0] <= mem_rd_en ? ram[mem_addr] : $urandom();
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // Reference model state.
  logic [31:0] ref_mem [NWORDS];

  typedef struct {
    bit                err;
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;
  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];
  int   busy_from = 0;
  int   free_at   = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_txn  = 0;
  int   last_c = 0;
  logic [ADDR_W-1:0] last_w;
  logic [31:0]       last_old;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit is_legal(logic [2:0] f, logic [31:0] a);
    case (f)
      3'b000:  return 1'b1;
      3'b001:  return a[0] == 1'b0;
      3'b010:  return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(logic [31:0] old, logic [31:0] d,
                                            logic [2:0] f, logic [1:0] lane);
    int sh;
    logic [31:0] m;
    if (f == 3'b000) begin
      sh = 8 * lane;
      m  = 32'h0000_00FF << sh;
    end else if (f == 3'b001) begin
      sh = 16 * lane[1];
      m  = 32'h0000_FFFF << sh;
    end else begin
      return d;
    end
    return (old & ~m) | ((d << sh) & m);
  endfunction

  // Scoreboard monitor: samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    rd_t  r;
    if (rstn) begin
      chk("req_ready", {31'b0, req_ready},
          (cyc >= busy_from && cyc < free_at) ? 32'd0 : 32'd1);
      chk("rd_we_exclusive", {31'b0, mem_rd_en & mem_we}, 32'd0);
      if (mem_rd_en) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_rd_en", 32'd1, 32'd0);
        end else begin
          r = rd_q.pop_front();
          chk("rd_cycle", cyc, r.cyc);
          chk("rd_addr", {18'b0, mem_addr}, {18'b0, r.addr});
        end
      end
      if (mem_we || done || misalign) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {29'b0, mem_we, done, misalign}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("misalign", {31'b0, misalign}, {31'b0, e.err});
          chk("done", {31'b0, done}, {31'b0, !e.err});
          chk("mem_we", {31'b0, mem_we}, {31'b0, !e.err});
          chk("out_cycle", cyc, e.cyc);
          if (!e.err) begin
            chk("mem_addr", {18'b0, mem_addr}, {18'b0, e.addr});
            chk("mem_wdata", mem_wdata, e.data);
          end
        end
      end
    end
  end

  // Present a request, wait (bounded) for acceptance, record expectations.
  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input bit hold);
    int c;
    int e;
    int wait_n = 0;
    logic [ADDR_W-1:0] w;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f;
    req_valid  = 1'b1;
    while (!req_ready) begin
      if (wait_n == 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      wait_n++;
    end
    c = cyc;
    last_c = c;
    w = a[ADDR_W+1:2];
    last_w = w;
    last_old = ref_mem[w];
    if (!is_legal(f, a)) begin
      e = c + 1;
      exp_q.push_back('{1'b1, e, w, 32'h0});
    end else if (f == 3'b010) begin
      e = c + 1;
      ref_mem[w] = d;
      exp_q.push_back('{1'b0, e, w, d});
    end else begin
      e = c + 2 + LAT;
      ref_mem[w] = ref_merge(ref_mem[w], d, f, a[1:0]);
      rd_q.push_back('{c + 1, w});
      exp_q.push_back('{1'b0, e, w, ref_mem[w]});
    end
    busy_from = c + 1;
    free_at   = e + 1;
    n_txn++;
    $display("txn %0d @%0d: f3=%0d addr=0x%08h data=0x%08h -> %s", n_txn, c, f, a, d,
             is_legal(f, a) ? $sformatf("word[0x%0h]=0x%08h at %0d", w, ref_mem[w], e)
                            : $sformatf("misalign at %0d", e));
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < free_at) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    int r;
    int c1;
    for (int i = 0; i < 128; i++) begin
      v = $urandom();
      ram[i] <= v;
      ref_mem[i] = v;
    end
    repeat (2) @(posedge clk);
    #1;
    // Reset values.
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    chk("rst_mem_rd_en", {31'b0, mem_rd_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {18'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios on word 0x40.
    issue(32'h100, 32'h1234_5678, 3'b010, 1'b0); wait_idle();
    chk("sw_word", ram[14'h40], 32'h1234_5678);
    issue(32'h100, 32'hAABB_CCDD, 3'b010, 1'b0); wait_idle();
    issue(32'h101, 32'h0000_00EE, 3'b000, 1'b0); wait_idle();
    chk("sb_word", ram[14'h40], 32'hAABB_EEDD);
    issue(32'h100, 32'hAABB_CCDD, 3'b010, 1'b0); wait_idle();
    issue(32'h102, 32'hFFFF_1234, 3'b001, 1'b0); wait_idle();
    chk("sh_hi_word", ram[14'h40], 32'h1234_CCDD);
    issue(32'h100, 32'hAABB_CCDD, 3'b010, 1'b0); wait_idle();
    issue(32'h100, 32'hFFFF_1234, 3'b001, 1'b0); wait_idle();
    chk("sh_lo_word", ram[14'h40], 32'hAABB_1234);

    // Rejected requests.
    issue(32'h103, 32'h1111_2222, 3'b001, 1'b0); wait_idle();
    issue(32'h102, 32'h3333_4444, 3'b010, 1'b0); wait_idle();
    issue(32'h100, 32'h5555_6666, 3'b011, 1'b0); wait_idle();
    chk("err_no_write", ram[14'h40], 32'hAABB_1234);

    // Back-to-back SW with req_valid held high.
    issue(32'h200, 32'hCAFE_0001, 3'b010, 1'b1);
    c1 = last_c;
    issue(32'h204, 32'hCAFE_0002, 3'b010, 1'b0);
    chk("b2b_accept_cycle", last_c, c1 + 2);
    wait_idle();

    // Reset while waiting for read data: the store must be abandoned.
    issue(32'h105, 32'h0000_0077, 3'b000, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_mem_we", {31'b0, mem_we}, 32'd0);
    chk("abort_mem_rd_en", {31'b0, mem_rd_en}, 32'd0);
    chk("abort_mem_addr", {18'b0, mem_addr}, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    exp_q.delete();
    rd_q.delete();
    ref_mem[last_w] = last_old;
    busy_from = 0;
    free_at   = 0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", {31'b0, req_ready}, 32'd1);

    // Random traffic.
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      f = 3'b000;
      else if (r < 6) f = 3'b001;
      else if (r < 9) f = 3'b010;
      else            f = 3'($urandom_range(3, 7));
      a = ($urandom() << 16) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      if (f != 3'b000 && $urandom_range(0, 3) != 0) begin
        a[1:0] = (f == 3'b001) ? {a[1], 1'b0} : 2'b00;
      end
      d = $urandom();
      issue(a, d, f, $urandom_range(0, 2) == 0);
      if (!req_valid) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
    end
    req_valid = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    for (int i = 0; i < 128; i++) begin
      chk($sformatf("ram_word_%0d", i), ram[i], ref_mem[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
